// File: rtl/otter_rf_pkg.sv
// rtl/otter_rf_pkg.sv - shared widths and types for the OTTER register-file write-back path
package otter_rf_pkg;

  localparam int XLEN      = 32;
  localparam int NREG      = 32;
  localparam int REG_ADR_W = $clog2(NREG);

  typedef struct packed {
    logic                 valid;
    logic [REG_ADR_W-1:0] adr;
    logic [XLEN-1:0]      data;
  } wb_req_t;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_t;

  function automatic logic is_real_write(input wb_req_t req);
    return req.valid && (req.adr != '0);
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - pending-destination scoreboard with RAW/WAW stall generation
module rf_scoreboard
  import otter_rf_pkg::*;
(
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 RF_EN,
  input  logic [REG_ADR_W-1:0] RF_WA,
  input  logic                 RES_EN,
  input  logic [REG_ADR_W-1:0] RES_ADR,
  input  logic [REG_ADR_W-1:0] SRC_ADR1,
  input  logic [REG_ADR_W-1:0] SRC_ADR2,
  output logic                 HAZ,
  output logic [NREG-1:0]      BUSY
);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] set_mask;
  logic [NREG-1:0] clr_mask;

  // Looked up from the registered bits, so a register being written this cycle still stalls.
  assign HAZ  = !RST && RES_EN &&
                (busy_q[SRC_ADR1] || busy_q[SRC_ADR2] || busy_q[RES_ADR]);
  assign BUSY = busy_q;

  // Loop starts at 1 so x0 can never be marked busy.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    for (int i = 1; i < NREG; i++) begin
      clr_mask[i] = RF_EN && (RF_WA == REG_ADR_W'(i));
      set_mask[i] = RES_EN && !HAZ && (RES_ADR == REG_ADR_W'(i));
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      busy_q <= '0;
    end else begin
      busy_q <= (busy_q & ~clr_mask) | set_mask;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin write-port arbiter for the OTTER register file
module regfile_wb_arbiter
  import otter_rf_pkg::*;
(
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 RES_EN,
  input  logic [REG_ADR_W-1:0] RES_ADR,
  input  logic [REG_ADR_W-1:0] SRC_ADR1,
  input  logic [REG_ADR_W-1:0] SRC_ADR2,
  output logic                 HAZ,
  input  logic                 A_VALID,
  input  logic [REG_ADR_W-1:0] A_ADR,
  input  logic [XLEN-1:0]      A_DATA,
  output logic                 A_READY,
  input  logic                 B_VALID,
  input  logic [REG_ADR_W-1:0] B_ADR,
  input  logic [XLEN-1:0]      B_DATA,
  output logic                 B_READY,
  output logic                 RF_EN,
  output logic [REG_ADR_W-1:0] RF_WA,
  output logic [XLEN-1:0]      RF_WD,
  output logic [NREG-1:0]      BUSY
);

  wb_req_t req_a;
  wb_req_t req_b;
  req_id_t last_q;
  logic    a_real, b_real;
  logic    a_zero, b_zero;
  logic    grant_a, grant_b;

  assign req_a = {A_VALID, A_ADR, A_DATA};
  assign req_b = {B_VALID, B_ADR, B_DATA};

  assign a_real = is_real_write(req_a);
  assign b_real = is_real_write(req_b);
  assign a_zero = req_a.valid && (req_a.adr == '0);
  assign b_zero = req_b.valid && (req_b.adr == '0);

  // Under contention the requester that did not win last time goes first.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!RST) begin
      grant_a = a_real && (!b_real || (last_q == REQ_B));
      grant_b = b_real && (!a_real || (last_q == REQ_A));
    end
  end

  // x0 writes complete without touching the port, alongside any real grant.
  always_comb begin
    A_READY = !RST && (a_zero || grant_a);
    B_READY = !RST && (b_zero || grant_b);
    RF_EN   = grant_a || grant_b;
    RF_WA   = '0;
    RF_WD   = '0;
    if (grant_a) begin
      RF_WA = req_a.adr;
      RF_WD = req_a.data;
    end else if (grant_b) begin
      RF_WA = req_b.adr;
      RF_WD = req_b.data;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      last_q <= REQ_B;
    end else if (grant_a) begin
      last_q <= REQ_A;
    end else if (grant_b) begin
      last_q <= REQ_B;
    end
  end

  rf_scoreboard u_scoreboard (
    .CLK      (CLK),
    .RST      (RST),
    .RF_EN    (RF_EN),
    .RF_WA    (RF_WA),
    .RES_EN   (RES_EN),
    .RES_ADR  (RES_ADR),
    .SRC_ADR1 (SRC_ADR1),
    .SRC_ADR2 (SRC_ADR2),
    .HAZ      (HAZ),
    .BUSY     (BUSY)
  );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - scoreboard bench for regfile_wb_arbiter with a behavioural model
module tb_regfile_wb_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic        RES_EN;
  logic [4:0]  RES_ADR, SRC_ADR1, SRC_ADR2;
  logic        HAZ;
  logic        A_VALID, B_VALID;
  logic [4:0]  A_ADR, B_ADR;
  logic [31:0] A_DATA, B_DATA;
  logic        A_READY, B_READY;
  logic        RF_EN;
  logic [4:0]  RF_WA;
  logic [31:0] RF_WD;
  logic [31:0] BUSY;

  always #5 CLK = ~CLK;

  regfile_wb_arbiter dut (
    .CLK(CLK), .RST(RST), .RES_EN(RES_EN), .RES_ADR(RES_ADR),
    .SRC_ADR1(SRC_ADR1), .SRC_ADR2(SRC_ADR2), .HAZ(HAZ),
    .A_VALID(A_VALID), .A_ADR(A_ADR), .A_DATA(A_DATA), .A_READY(A_READY),
    .B_VALID(B_VALID), .B_ADR(B_ADR), .B_DATA(B_DATA), .B_READY(B_READY),
    .RF_EN(RF_EN), .RF_WA(RF_WA), .RF_WD(RF_WD), .BUSY(BUSY)
  );

  typedef struct {
    bit        a_ready;
    bit        b_ready;
    bit        rf_en;
    bit [4:0]  wa;
    bit [31:0] wd;
    bit        haz;
    bit [31:0] busy;
    bit        busy_known;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference state: which registers await a write, and who won the last real write.
  bit   m_busy[32];
  bit   m_known = 1'b0;
  int   m_last = 1;          // 0 = A, 1 = B
  int   cur_winner;          // -1 none, 0 A, 1 B
  bit   cur_haz;
  exp_t cur;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Set the inputs for one cycle and queue what the DUT must show during it.
  task automatic apply(input bit rst, input bit av, input bit [4:0] aa, input bit [31:0] ad,
                       input bit bv, input bit [4:0] ba, input bit [31:0] bd,
                       input bit re, input bit [4:0] ra, input bit [4:0] s1, input bit [4:0] s2);
    bit a_real, b_real;
    RST = rst; A_VALID = av; A_ADR = aa; A_DATA = ad;
    B_VALID = bv; B_ADR = ba; B_DATA = bd;
    RES_EN = re; RES_ADR = ra; SRC_ADR1 = s1; SRC_ADR2 = s2;
    cur = '{default: 0};
    cur_winner = -1;
    cur_haz = 1'b0;
    for (int i = 0; i < 32; i++) cur.busy[i] = m_busy[i];
    cur.busy_known = m_known;
    if (!rst) begin
      a_real = av && (aa != 0);
      b_real = bv && (ba != 0);
      if (a_real && b_real) cur_winner = (m_last == 0) ? 1 : 0;
      else if (a_real)      cur_winner = 0;
      else if (b_real)      cur_winner = 1;
      cur.a_ready = av && (aa == 0 || cur_winner == 0);
      cur.b_ready = bv && (ba == 0 || cur_winner == 1);
      cur.rf_en   = (cur_winner != -1);
      cur.wa      = (cur_winner == 0) ? aa : (cur_winner == 1) ? ba : 5'd0;
      cur.wd      = (cur_winner == 0) ? ad : (cur_winner == 1) ? bd : 32'd0;
      cur_haz     = re && (m_busy[s1] || m_busy[s2] || m_busy[ra]);
      cur.haz     = cur_haz;
    end
    exp_q.push_back(cur);
  endtask

  // Advance one edge and let the reference state follow the rules.
  task automatic tick();
    @(posedge CLK);
    if (RST) begin
      foreach (m_busy[i]) m_busy[i] = 1'b0;
      m_last  = 1;
      m_known = 1'b1;
    end else begin
      if (cur_winner != -1) begin
        m_busy[cur.wa] = 1'b0;
        m_last = cur_winner;
      end
      if (RES_EN && !cur_haz && RES_ADR != 0) m_busy[RES_ADR] = 1'b1;
    end
    #1;
  endtask

  always @(negedge CLK) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("A_READY", {31'd0, A_READY}, {31'd0, e.a_ready});
      chk("B_READY", {31'd0, B_READY}, {31'd0, e.b_ready});
      chk("RF_EN",   {31'd0, RF_EN},   {31'd0, e.rf_en});
      chk("RF_WA",   {27'd0, RF_WA},   {27'd0, e.wa});
      chk("RF_WD",   RF_WD,            e.wd);
      chk("HAZ",     {31'd0, HAZ},     {31'd0, e.haz});
      if (e.busy_known) chk("BUSY", BUSY, e.busy);
    end
  end

  bit        a_pend, b_pend;
  bit [4:0]  pa, pb;
  bit [31:0] da, db;

  initial begin
    @(posedge CLK); #1;
    apply(1, 0,0,0, 0,0,0, 0,0,0,0); tick();
    apply(1, 0,0,0, 0,0,0, 0,0,0,0); tick();

    // Single requester gets the port in the same cycle.
    apply(0, 1,5,32'hDEADBEEF, 0,0,0, 0,0,0,0);
    #3; chk("single A_READY", {31'd0, A_READY}, 32'd1);
    chk("single RF_WA", {27'd0, RF_WA}, 32'd5);
    chk("single RF_WD", RF_WD, 32'hDEADBEEF);
    tick();

    // Reset again so A must win the first contention, then alternate.
    apply(1, 0,0,0, 0,0,0, 0,0,0,0); tick();
    for (int k = 0; k < 3; k++) begin
      apply(0, 1,3,32'h11, 1,4,32'h22, 0,0,0,0);
      #3; chk("rr RF_WA", {27'd0, RF_WA}, (k == 1) ? 32'd4 : 32'd3);
      chk("rr loser READY", {31'd0, (k == 1) ? A_READY : B_READY}, 32'd0);
      tick();
    end

    // x0 write rides alongside a real write.
    apply(0, 1,0,32'h55, 1,7,32'h77, 0,0,0,0);
    #3; chk("x0 both READY", {30'd0, A_READY, B_READY}, 32'd3);
    chk("x0 RF_WA", {27'd0, RF_WA}, 32'd7);
    tick();

    // Reserve x9, then stall on it until B writes it.
    apply(0, 0,0,0, 0,0,0, 1,9,1,2); tick();
    apply(0, 0,0,0, 0,0,0, 1,10,9,0);
    #3; chk("res BUSY9", {31'd0, BUSY[9]}, 32'd1);
    chk("raw HAZ", {31'd0, HAZ}, 32'd1);
    tick();
    apply(0, 0,0,0, 1,9,32'h99, 1,10,9,0);
    #3; chk("haz during write", {31'd0, HAZ}, 32'd1);
    tick();
    apply(0, 0,0,0, 0,0,0, 1,10,9,0);
    #3; chk("haz cleared", {31'd0, HAZ}, 32'd0);
    tick();

    // x0 reservation is ignored.
    apply(0, 0,0,0, 0,0,0, 1,0,0,0); tick();
    apply(0, 0,0,0, 0,0,0, 1,0,0,0);
    #3; chk("x0 res HAZ", {31'd0, HAZ}, 32'd0);
    chk("x0 res BUSY0", {31'd0, BUSY[0]}, 32'd0);
    tick();

    // Reset mid-transfer with x8/x9 busy.
    apply(1, 0,0,0, 0,0,0, 0,0,0,0); tick();
    apply(0, 0,0,0, 0,0,0, 1,8,0,0); tick();
    apply(0, 0,0,0, 0,0,0, 1,9,0,0); tick();
    apply(1, 1,12,32'hA, 1,13,32'hB, 0,0,0,0);
    #3; chk("rst BUSY", BUSY, 32'h0000_0300);
    chk("rst outputs", {29'd0, A_READY, B_READY, RF_EN}, 32'd0);
    tick();
    apply(0, 1,12,32'hA, 1,13,32'hB, 0,0,0,0);
    #3; chk("post-rst BUSY", BUSY, 32'd0);
    chk("post-rst winner", {30'd0, A_READY, B_READY}, 32'd2);
    tick();

    // Randomized traffic with held requests and occasional resets.
    a_pend = 0; b_pend = 0;
    for (int n = 0; n < 800; n++) begin
      if (!a_pend && $urandom_range(0, 2) != 0) begin
        a_pend = 1; pa = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 15)); da = $urandom;
      end
      if (!b_pend && $urandom_range(0, 2) != 0) begin
        b_pend = 1; pb = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 15)); db = $urandom;
      end
      apply($urandom_range(0, 60) == 0, a_pend, pa, da, b_pend, pb, db,
            $urandom_range(0, 1) == 1, 5'($urandom_range(0, 15)),
            5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)));
      if (cur.a_ready) a_pend = 0;
      if (cur.b_ready) b_pend = 0;
      tick();
    end

    apply(0, 0,0,0, 0,0,0, 0,0,0,0); tick();
    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge CLK);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
